// File: rtl/uart_nib_rx.sv
// 8N1 serial receiver that decodes ASCII hex characters into 4-bit values.
// Reports the raw framed byte, the decoded nibble, and non-hex and framing errors.
module uart_nib_rx #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [3:0] in_nib,
  output logic       nib_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       hex_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t        state_q, state_d;
  logic          meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    nib_q, nib_d;
  logic [1:0]    settle_q, settle_d;
  logic          nib_valid_q, nib_valid_d;
  logic          byte_valid_q, byte_valid_d;
  logic          hex_err_q, hex_err_d;
  logic          frame_err_q, frame_err_d;
  logic          hex_ok;
  logic [3:0]    hex_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= uart_rx;
      rxs_q  <= meta_q;
    end
  end

  always_comb begin
    hex_ok  = 1'b0;
    hex_val = 4'd0;
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_val = shift_q[3:0];
    end else if ((shift_q >= 8'h41 && shift_q <= 8'h46) ||
                 (shift_q >= 8'h61 && shift_q <= 8'h66)) begin
      hex_ok  = 1'b1;
      hex_val = shift_q[3:0] + 4'd9;
    end
  end

  // The synchronizer comes out of reset holding 1s, so WAIT_HI ignores rxs
  // until both stages have been refilled from the pin after reset release.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    nib_d        = nib_q;
    settle_d     = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    nib_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    hex_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (settle_q == 2'd2 && rxs_q) state_d = IDLE;
      end
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            idx_d   = 3'd0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
            if (hex_ok) begin
              nib_d       = hex_val;
              nib_valid_d = 1'b1;
            end else begin
              hex_err_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_HI;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_q       <= 8'd0;
      nib_q        <= 4'd0;
      settle_q     <= 2'd0;
      nib_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      hex_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      nib_q        <= nib_d;
      settle_q     <= settle_d;
      nib_valid_q  <= nib_valid_d;
      byte_valid_q <= byte_valid_d;
      hex_err_q    <= hex_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign in_nib     = nib_q;
  assign nib_valid  = nib_valid_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign hex_err    = hex_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_nib_rx.sv
// Directed bench for uart_nib_rx: table of characters plus hand-written
// sequences for back-to-back frames, glitches, framing errors and mid-frame reset.
module tb_uart_nib_rx;

  localparam int BIT = 104;
  localparam int LAT = 991;  // start-bit drive edge to result edge: 2 sync + 1 detect + 988

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [3:0] in_nib;
  logic       nib_valid, byte_valid, hex_err, frame_err, rx_busy;
  logic [7:0] byte_out;

  uart_nib_rx dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .in_nib(in_nib), .nib_valid(nib_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .hex_err(hex_err),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_bv = 0, n_nv = 0, n_he = 0, n_fe = 0, n_busy = 0;
  int bv_cyc = -1, fe_cyc = -1;
  logic [3:0] nib_vals[$];
  int         nib_cycs[$];
  always @(negedge clk) begin
    if (byte_valid) begin n_bv++; bv_cyc = cyc; end
    if (hex_err) n_he++;
    if (frame_err) begin n_fe++; fe_cyc = cyc; end
    if (rx_busy) n_busy++;
    if (nib_valid) begin
      n_nv++;
      nib_vals.push_back(in_nib);
      nib_cycs.push_back(cyc);
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, output int s);
    s = cyc;
    uart_rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(BIT);
    end
    uart_rx = 1'b1;
    step(BIT);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       exp_nv;
    logic [3:0] exp_nib;
  } vec_t;

  vec_t vecs[15];
  int s, bv0, nv0, he0, fe0, busy0, base;
  logic [7:0] chars[3];
  logic [3:0] exp3[3];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'h37, 1'b1, 4'h7};
    vecs[1]  = '{8'h47, 1'b0, 4'h7};
    vecs[2]  = '{8'h0D, 1'b0, 4'h7};
    vecs[3]  = '{8'h30, 1'b1, 4'h0};
    vecs[4]  = '{8'h2F, 1'b0, 4'h0};
    vecs[5]  = '{8'h39, 1'b1, 4'h9};
    vecs[6]  = '{8'h3A, 1'b0, 4'h9};
    vecs[7]  = '{8'h40, 1'b0, 4'h9};
    vecs[8]  = '{8'h41, 1'b1, 4'hA};
    vecs[9]  = '{8'h46, 1'b1, 4'hF};
    vecs[10] = '{8'h47, 1'b0, 4'hF};
    vecs[11] = '{8'h60, 1'b0, 4'hF};
    vecs[12] = '{8'h61, 1'b1, 4'hA};
    vecs[13] = '{8'h66, 1'b1, 4'hF};
    vecs[14] = '{8'h67, 1'b0, 4'hF};

    // Reset and idle
    step(5);
    chk("rst_in_nib", in_nib, 4'h0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_busy", rx_busy, 1'b0);
    rst = 1'b0;
    busy0 = n_busy;
    step(50);
    chk("idle_busy_cnt", n_busy - busy0, 0);
    chk("idle_pulses", n_bv + n_nv + n_he + n_fe, 0);
    chk("idle_in_nib", in_nib, 4'h0);
    chk("idle_byte_out", byte_out, 8'h00);

    // Table of single characters
    for (int v = 0; v < 15; v++) begin
      bv0 = n_bv; nv0 = n_nv; he0 = n_he; fe0 = n_fe;
      send_frame(vecs[v].ch, s);
      chk($sformatf("v%0d_bv_cnt", v), n_bv - bv0, 1);
      chk($sformatf("v%0d_nv_cnt", v), n_nv - nv0, {31'd0, vecs[v].exp_nv});
      chk($sformatf("v%0d_he_cnt", v), n_he - he0, {31'd0, ~vecs[v].exp_nv});
      chk($sformatf("v%0d_fe_cnt", v), n_fe - fe0, 0);
      chk($sformatf("v%0d_bv_time", v), bv_cyc - s, LAT);
      chk($sformatf("v%0d_byte_out", v), byte_out, vecs[v].ch);
      chk($sformatf("v%0d_in_nib", v), in_nib, vecs[v].exp_nib);
      chk($sformatf("v%0d_busy", v), rx_busy, 1'b0);
      step(5);
    end

    // Back-to-back c, F, a with no idle gap
    chars[0] = 8'h63; chars[1] = 8'h46; chars[2] = 8'h61;
    exp3[0] = 4'hC; exp3[1] = 4'hF; exp3[2] = 4'hA;
    base = nib_vals.size();
    for (int i = 0; i < 3; i++) send_frame(chars[i], s);
    step(2);
    chk("b2b_count", nib_vals.size() - base, 3);
    if (nib_vals.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_nib%0d", i), nib_vals[base + i], exp3[i]);
      chk("b2b_gap1", nib_cycs[base + 1] - nib_cycs[base], 1040);
      chk("b2b_gap2", nib_cycs[base + 2] - nib_cycs[base + 1], 1040);
    end

    // Glitch: 30 low clocks
    step(5);
    bv0 = n_bv; nv0 = n_nv; he0 = n_he; fe0 = n_fe;
    s = cyc;
    uart_rx = 1'b0;
    step(30);
    uart_rx = 1'b1;
    step(24);
    chk("glitch_busy_before", rx_busy, 1'b1);
    step(1);
    chk("glitch_busy_after", rx_busy, 1'b0);
    step(100);
    chk("glitch_pulses", (n_bv - bv0) + (n_nv - nv0) + (n_he - he0) + (n_fe - fe0), 0);
    chk("glitch_in_nib", in_nib, 4'hA);

    // Break: line low for 3000 clocks
    bv0 = n_bv; nv0 = n_nv; he0 = n_he; fe0 = n_fe;
    s = cyc;
    uart_rx = 1'b0;
    step(1500);
    busy0 = n_busy;
    step(1500);
    chk("brk_fe_cnt", n_fe - fe0, 1);
    chk("brk_fe_time", fe_cyc - s, LAT);
    chk("brk_bv_cnt", n_bv - bv0, 0);
    chk("brk_nv_he_cnt", (n_nv - nv0) + (n_he - he0), 0);
    chk("brk_quiet_busy", n_busy - busy0, 0);
    chk("brk_in_nib", in_nib, 4'hA);
    chk("brk_byte_out", byte_out, 8'h61);
    uart_rx = 1'b1;
    step(20);
    nv0 = n_nv;
    send_frame(8'h33, s);
    chk("brk_next_nv", n_nv - nv0, 1);
    chk("brk_next_nib", in_nib, 4'h3);

    // Reset during data bit 4 of '9', released with the line low
    step(5);
    bv0 = n_bv; nv0 = n_nv; he0 = n_he; fe0 = n_fe;
    chars[0] = 8'h39;
    uart_rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = chars[0][i];
      step(BIT);
    end
    uart_rx = chars[0][4];
    step(50);
    chk("mid_busy_pre", rx_busy, 1'b1);
    rst = 1'b1;
    uart_rx = 1'b0;
    step(1);
    chk("mid_rst_in_nib", in_nib, 4'h0);
    chk("mid_rst_byte_out", byte_out, 8'h00);
    chk("mid_rst_busy", rx_busy, 1'b0);
    step(4);
    rst = 1'b0;
    busy0 = n_busy;
    step(300);
    chk("mid_low_busy", n_busy - busy0, 0);
    chk("mid_pulses", (n_bv - bv0) + (n_nv - nv0) + (n_he - he0) + (n_fe - fe0), 0);
    chk("mid_in_nib", in_nib, 4'h0);
    uart_rx = 1'b1;
    step(20);
    nv0 = n_nv;
    send_frame(8'h35, s);
    chk("mid_next_nv", n_nv - nv0, 1);
    chk("mid_next_nib", in_nib, 4'h5);
    chk("mid_next_byte", byte_out, 8'h35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_nib_rx.md
# uart_nib_rx

UART receiver that turns ASCII hex characters arriving on a serial line into 4-bit values for the CPU input port. It is the receive-side counterpart of the OUT-nibble UART transmitter. It sits beside the CPU core in the system top: `in_nib` may drive the core's `in[3:0]` in place of the switches, and `byte_out`/`byte_valid` are available for debug.

## Interface
- `CLK_HZ`, default 12_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- Derived constants:
  - `BIT_CNT = CLK_HZ/BAUD`, integer truncation; 104 at defaults; must be ≥ 4.
  - `HALF = BIT_CNT/2`; 52 at defaults.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: raw serial line. Asynchronous to `clk`; idles high.
- `in_nib` out 4: last successfully decoded hex value.
- `nib_valid` out 1: 1-cycle pulse; `in_nib` was just updated.
- `byte_out` out 8: last correctly framed byte.
- `byte_valid` out 1: 1-cycle pulse; `byte_out` was just updated.
- `hex_err` out 1: 1-cycle pulse; a correctly framed byte was not a hex character.
- `frame_err` out 1: 1-cycle pulse; the stop bit was sampled low.
- `rx_busy` out 1: high in states START, DATA and STOP.

## Operation
- **Input sync:** `uart_rx` passes through a 2-flop synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value `rxs`.
- **Format:** 8N1, LSB first. The bit counter `cnt` is `$clog2(BIT_CNT)` bits wide. The bit index is 3 bits wide.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HI. The reset state is WAIT_HI.
- **WAIT_HI:** when `rxs`==1, go to IDLE. This keeps a line that is low at reset, or during a break, from being taken as a start bit.
- **IDLE:** when `rxs`==0, go to START with `cnt`=0.
- **START:**
  - `cnt` counts up each clock.
  - At `cnt`==HALF-1, sample `rxs`.
  - If the sample is 1 (glitch), return to IDLE with no pulses.
  - If the sample is 0, set `cnt`=0 and bit index=0, and go to DATA.
- **DATA:**
  - At `cnt`==BIT_CNT-1, shift `rxs` into bit 7 of the shift register (right shift), clear `cnt`, and increment the bit index.
  - After the 8th sample, go to STOP.
- **STOP:** at `cnt`==BIT_CNT-1, sample `rxs`.
  - **Sample 1:**
    - `byte_out`<=shift register; pulse `byte_valid`.
    - Hex decode:
      - 0x30–0x39 → 0–9.
      - 0x41–0x46 → 10–15.
      - 0x61–0x66 → 10–15.
    - On a hex match: `in_nib`<=value and pulse `nib_valid`.
    - Otherwise: pulse `hex_err` and leave `in_nib` unchanged.
    - Go to IDLE.
  - **Sample 0:** pulse `frame_err`. `byte_out` and `in_nib` are unchanged and no other pulse fires. Go to WAIT_HI.
- **Exclusivity:** every pulse is registered and high for exactly one clock. At most one of `nib_valid`/`hex_err`/`frame_err` fires per frame. `byte_valid` fires together with `nib_valid` or `hex_err`, never with `frame_err`.
- **Back-to-back frames:** from IDLE, a new start bit is detected on the clock immediately after the STOP sample. A sender using one stop bit is therefore received without loss.
- **Reset values:** `in_nib`=0, `byte_out`=0, all pulses 0, `rx_busy`=0, shift register 0, `cnt`=0.
- **Reset mid-frame:** the frame is aborted silently, with no pulses. After reset release the FSM sits in WAIT_HI until the line is high.

## Timing
- t0 is the first `clk` edge at which IDLE sees `rxs`==0. `rxs` lags the pin by 2 clocks.
- Start check: edge t0+HALF (52).
- Data bit k (k=0..7) sampled at edge t0+HALF+(k+1)·BIT_CNT: t0+156 … t0+884.
- Stop sampled at edge t0+HALF+9·BIT_CNT = t0+988. All result outputs and pulses are visible immediately after that edge.
- Pin-to-pulse latency is ≈ 990 clocks at the defaults.
- `rx_busy` rises the clock after t0 and falls with the stop-sample edge.
- Tolerated baud mismatch is about ±4% total. This is a design limit, not a checked condition.

## Test plan
1. **Reset and idle:** assert `rst` with the line high, release, wait 50 clocks.
   - WAIT_HI→IDLE within 3 clocks of release.
   - All outputs at reset values; `rx_busy`=0; no pulses.
2. **Single character:** send '7' (0x37) at BIT_CNT=104.
   - At t0+988: `byte_valid` and `nib_valid` each high for 1 clock; `byte_out`=0x37, `in_nib`=7.
   - `hex_err`=`frame_err`=0.
3. **Back-to-back:** send 'c' (0x63), then 'F' (0x46), then 'a' (0x61) with one stop bit and no idle gap.
   - Three `nib_valid` pulses, 1040 clocks apart.
   - `in_nib` sequence C, F, A.
4. **Non-hex character:** send 'G' (0x47), then 0x0D.
   - Each gives `byte_valid` plus `hex_err` with `byte_out` 0x47 then 0x0D.
   - `in_nib` holds its prior value; no `nib_valid`.
5. **Glitch and framing error:**
   - Pulse the line low for 30 clocks → no pulses, `rx_busy` drops 52 clocks after t0, FSM in IDLE.
   - Hold the line low for 3000 clocks → exactly one `frame_err` at t0+988, no `byte_valid`, no further activity until the line goes high; the next '3' then decodes to `in_nib`=3.
6. **Reset mid-frame:** assert `rst` during data bit 4 of '9'.
   - No pulses, outputs return to reset values.
   - After release with the line low, no start is detected until the line goes high; the next frame '5' yields `in_nib`=5.
